// File: rtl/fib_sched_if.sv
// fib_sched_if: requester-side bundle for fib_job_scheduler.
// Carries job requests, one-hot grants, busy and tagged responses.
interface fib_sched_if #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int ORDER_WIDTH = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*ORDER_WIDTH-1:0] req_order;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_start;
   logic [NUM_REQ-1:0]             gnt;
   logic                           busy;
   logic                           rsp_valid;
   logic [ID_W-1:0]                rsp_id;
   logic [DATA_WIDTH-1:0]          rsp_data;
   logic                           rsp_error;
   logic                           rsp_overflow;
   logic                           rsp_timeout;

   modport master (
      output req, req_order, req_start,
      input  gnt, busy, rsp_valid, rsp_id,
      input  rsp_data, rsp_error, rsp_overflow,
      input  rsp_timeout
   );

   modport slave (
      input  req, req_order, req_start,
      output gnt, busy, rsp_valid, rsp_id,
      output rsp_data, rsp_error, rsp_overflow,
      output rsp_timeout
   );
endinterface

// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: round-robin sharing of one Fibonacci generator.
// Optional order precheck enabled by defining FIB_SCHED_PRECHECK_EN.
module fib_job_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 64,
   parameter int ORDER_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_ORDER      = 93
) (
   input  logic                   clk,
   input  logic                   reset,
   fib_sched_if.slave             bus,
   output logic                   gen_reset_n,
   output logic                   gen_load,
   output logic                   gen_clear,
   output logic [ORDER_WIDTH-1:0] gen_order,
   output logic [DATA_WIDTH-1:0]  gen_data_in,
   input  logic                   gen_done,
   input  logic                   gen_error,
   input  logic                   gen_overflow,
   input  logic [DATA_WIDTH-1:0]  gen_data_out
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_RESP    = 3'd3;
   localparam logic [2:0] S_CLEAR   = 3'd4;
   localparam logic [2:0] S_RECOVER = 3'd5;

   logic [2:0]             r_state;
   logic [ID_W-1:0]        r_ptr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_rec;
   logic                   r_skip_clear;
   logic                   r_pre_ovf;
   logic [ID_W-1:0]        r_job_id;
   logic [ORDER_WIDTH-1:0] r_job_order;
   logic [DATA_WIDTH-1:0]  r_job_start;
   logic [ID_W-1:0]        r_rsp_id;
   logic [DATA_WIDTH-1:0]  r_rsp_data;
   logic                   r_rsp_err;
   logic                   r_rsp_ovf;
   logic                   r_rsp_to;

   logic                   w_found;
   logic [ID_W-1:0]        w_win;
   logic [ID_W:0]          w_sum;
   logic [ID_W-1:0]        w_ptr_nxt;
   logic [ORDER_WIDTH-1:0] w_ord;
   logic [DATA_WIDTH-1:0]  w_start;
   logic                   w_pre_ovf;
   logic                   w_gen_hit;
   logic                   w_tc;

   // Round-robin search: first pending requester at or after r_ptr.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(NUM_REQ))
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         if (!w_found && bus.req[w_sum[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[ID_W-1:0];
         end
      end
   end

   // Select the winner's packed order and start value.
   always_comb begin
      w_ord   = '0;
      w_start = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == w_win) begin
            w_ord   = bus.req_order[i*ORDER_WIDTH +: ORDER_WIDTH];
            w_start = bus.req_start[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ-1)) ?
                      '0 : w_win + 1'b1;

`ifdef FIB_SCHED_PRECHECK_EN
   assign w_pre_ovf = (w_ord > ORDER_WIDTH'(MAX_ORDER));
`else
   assign w_pre_ovf = 1'b0;
`endif

   assign w_gen_hit = gen_done | gen_error;
   assign w_tc      = (r_cnt == CNT_W'(TIMEOUT_CYCLES-1));

   // Main job sequencer: arbitrate, load, run, respond, clean up.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_rec        <= 1'b0;
         r_skip_clear <= 1'b0;
         r_pre_ovf    <= 1'b0;
         r_job_id     <= '0;
         r_job_order  <= '0;
         r_job_start  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_job_id    <= w_win;
                  r_job_order <= w_ord;
                  r_job_start <= w_start;
                  r_pre_ovf   <= w_pre_ovf;
                  r_ptr       <= w_ptr_nxt;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_cnt <= '0;
               if (r_pre_ovf) begin
                  r_skip_clear <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_skip_clear <= 1'b0;
                  r_state      <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_gen_hit) begin
                  r_state <= S_RESP;
               end else if (w_tc) begin
                  r_rec   <= 1'b0;
                  r_state <= S_RECOVER;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RECOVER: begin
               if (r_rec) begin
                  r_skip_clear <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_rec <= 1'b1;
               end
            end
            S_RESP: begin
               r_state <= r_skip_clear ? S_IDLE : S_CLEAR;
            end
            S_CLEAR: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Response registers: loaded on entry to RESP, held until next RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_id   <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_rsp_ovf  <= 1'b0;
         r_rsp_to   <= 1'b0;
      end else if (r_state == S_LOAD && r_pre_ovf) begin
         r_rsp_id   <= r_job_id;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_rsp_ovf  <= 1'b1;
         r_rsp_to   <= 1'b0;
      end else if (r_state == S_RUN && w_gen_hit) begin
         r_rsp_id   <= r_job_id;
         r_rsp_data <= gen_data_out;
         r_rsp_err  <= gen_error;
         r_rsp_ovf  <= gen_overflow;
         r_rsp_to   <= 1'b0;
      end else if (r_state == S_RECOVER && r_rec) begin
         r_rsp_id   <= r_job_id;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_rsp_ovf  <= 1'b0;
         r_rsp_to   <= 1'b1;
      end
   end

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.gnt       = (r_state == S_LOAD) ?
                          (NUM_REQ'(1) << r_job_id) : '0;
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_id       = r_rsp_id;
   assign bus.rsp_data     = r_rsp_data;
   assign bus.rsp_error    = r_rsp_err;
   assign bus.rsp_overflow = r_rsp_ovf;
   assign bus.rsp_timeout  = r_rsp_to;

   assign gen_load    = (r_state == S_LOAD) && !r_pre_ovf;
   assign gen_clear   = (r_state == S_CLEAR);
   assign gen_reset_n = !reset && (r_state != S_RECOVER);
   assign gen_order   = r_job_order;
   assign gen_data_in = r_job_start;
endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb_fib_job_scheduler: scoreboard bench with a behavioural generator.
// Generator result is start + order after a programmable latency.
module tb_fib_job_scheduler;
   localparam int NR = 4;
   localparam int DW = 64;
   localparam int OW = 16;
   localparam int TO = 40;

   typedef struct packed {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic          err;
      logic          ovf;
      logic          to;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic gen_reset_n, gen_load, gen_clear;
   logic [OW-1:0] gen_order;
   logic [DW-1:0] gen_data_in;
   logic gen_done, gen_error, gen_overflow;
   logic [DW-1:0] gen_data_out;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t sb[$];

   logic gen_en = 1'b0;
   logic gen_err_f = 1'b0;
   logic gen_ovf_f = 1'b0;
   int gen_lat = 0;
   logic m_active = 1'b0;
   int m_cnt = 0;
   logic [OW-1:0] m_order = '0;
   logic [DW-1:0] m_start = '0;
   logic w_hit;

   fib_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW),
                  .ORDER_WIDTH(OW)) bus ();

   fib_job_scheduler #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .ORDER_WIDTH(OW),
      .TIMEOUT_CYCLES(TO), .MAX_ORDER(93)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .gen_reset_n(gen_reset_n), .gen_load(gen_load),
      .gen_clear(gen_clear), .gen_order(gen_order),
      .gen_data_in(gen_data_in), .gen_done(gen_done),
      .gen_error(gen_error), .gen_overflow(gen_overflow),
      .gen_data_out(gen_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural generator: done gen_lat RUN cycles after load.
   always @(posedge clk) begin
      if (reset || !gen_reset_n) m_active <= 1'b0;
      else if (gen_load) begin
         m_active <= 1'b1;
         m_cnt    <= 0;
         m_order  <= gen_order;
         m_start  <= gen_data_in;
      end else if (gen_clear || gen_done) m_active <= 1'b0;
      else if (m_active) m_cnt <= m_cnt + 1;
   end

   assign w_hit = m_active && gen_en && (m_cnt == gen_lat);
   assign gen_done     = w_hit;
   assign gen_error    = w_hit && gen_err_f;
   assign gen_overflow = w_hit && gen_ovf_f;
   assign gen_data_out = m_start + DW'(m_order);

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int i, input int ord,
                          input logic [DW-1:0] st);
      bus.req_order[i*OW +: OW] = OW'(ord);
      bus.req_start[i*DW +: DW] = st;
   endtask

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (bus.gnt != '0) ok = 1'b1;
      end
   endtask

   task automatic wait_rsp(input int lim, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < lim && !ok; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) ok = 1'b1;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pop_cmp(input string nm, input logic ok);
      exp_t e, g;
      n_chk++;
      g = {bus.rsp_id, bus.rsp_data, bus.rsp_error,
           bus.rsp_overflow, bus.rsp_timeout};
      if (!ok || sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s no response (ok=%b q=%0d)",
                  nm, ok, sb.size());
      end else begin
         e = sb.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s rsp got %h want %h", nm, g, e);
         end
      end
   endtask

   task automatic test_reset();
      bus.req = '0;
      bus.req_order = '0;
      bus.req_start = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.gnt, bus.rsp_valid, gen_load,
           gen_clear, gen_reset_n} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_ctl got %b want 0",
                  {bus.busy, bus.gnt, bus.rsp_valid,
                   gen_load, gen_clear, gen_reset_n});
      end
      n_chk++;
      if ({bus.rsp_id, bus.rsp_data, bus.rsp_error,
           bus.rsp_overflow, bus.rsp_timeout} !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp got %h want 0", bus.rsp_data);
      end
      reset = 1'b0;
      @(negedge clk);
      n_chk++;
      if (gen_reset_n !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got %b%b want 10",
                  gen_reset_n, bus.busy);
      end
   endtask

   task automatic test_single();
      logic ok;
      int t0;
      gen_en = 1'b1; gen_lat = 11;
      set_req(0, 10, 64'd1);
      bus.req = 4'b0001;
      wait_gnt(ok);
      t0 = cyc;
      n_chk++;
      if (!ok || bus.gnt !== 4'b0001 || gen_load !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gnt got %b/%b want 0001/1",
                  bus.gnt, gen_load);
      end
      n_chk++;
      if (gen_order !== 16'd10 || gen_data_in !== 64'd1) begin
         n_fail++;
         $display("FAIL single_gen got %0d/%0d want 10/1",
                  gen_order, gen_data_in);
      end
      bus.req = '0;
      sb.push_back('{id: 2'd0, data: 64'd11,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(40, ok);
      n_chk++;
      if (cyc - t0 != 13) begin
         n_fail++;
         $display("FAIL single_lat got %0d want 13", cyc - t0);
      end
      pop_cmp("single", ok);
      @(negedge clk);
      n_chk++;
      if (gen_clear !== 1'b1) begin
         n_fail++;
         $display("FAIL single_clear got %b want 1", gen_clear);
      end
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle got %b want 0", bus.busy);
      end
   endtask

   task automatic test_round_robin();
      logic ok;
      int tp, k;
      reset_dut();
      gen_en = 1'b1; gen_lat = 0;
      for (int i = 0; i < NR; i++)
         set_req(i, i + 3, DW'(100 * i + 7));
      bus.req = 4'b1111;
      tp = 0;
      for (int g = 0; g < 5; g++) begin
         k = g % NR;
         wait_gnt(ok);
         n_chk++;
         if (!ok || bus.gnt !== (4'b0001 << k)) begin
            n_fail++;
            $display("FAIL rr_order%0d got %b want %b",
                     g, bus.gnt, 4'b0001 << k);
         end
         if (g > 0) begin
            n_chk++;
            if (cyc - tp != 5) begin
               n_fail++;
               $display("FAIL rr_spacing%0d got %0d want 5",
                        g, cyc - tp);
            end
         end
         tp = cyc;
         if (g == 4) bus.req = '0;
         sb.push_back('{id: 2'(k),
                        data: DW'(100 * k + 7) + DW'(k + 3),
                        err: 0, ovf: 0, to: 0});
         wait_rsp(10, ok);
         pop_cmp("rr", ok);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic ok;
      int t0, lows;
      gen_en = 1'b0;
      set_req(2, 5, 64'd9);
      bus.req = 4'b0100;
      wait_gnt(ok);
      t0 = cyc;
      bus.req = '0;
      sb.push_back('{id: 2'd2, data: '0,
                     err: 0, ovf: 0, to: 1});
      lows = 0;
      ok = 1'b0;
      for (int c = 0; c < TO + 20 && !ok; c++) begin
         @(negedge clk);
         if (!gen_reset_n) lows++;
         if (bus.rsp_valid) ok = 1'b1;
      end
      n_chk++;
      if (cyc - t0 != TO + 3) begin
         n_fail++;
         $display("FAIL to_lat got %0d want %0d",
                  cyc - t0, TO + 3);
      end
      n_chk++;
      if (lows != 2) begin
         n_fail++;
         $display("FAIL to_genrst got %0d want 2", lows);
      end
      pop_cmp("timeout", ok);
      @(negedge clk);
      n_chk++;
      if (gen_clear !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_noclear got %b%b want 00",
                  gen_clear, bus.busy);
      end
      gen_en = 1'b1; gen_lat = 3;
      set_req(1, 7, 64'd20);
      bus.req = 4'b0010;
      wait_gnt(ok);
      n_chk++;
      if (!ok || bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL to_next_gnt got %b want 0010", bus.gnt);
      end
      bus.req = '0;
      sb.push_back('{id: 2'd1, data: 64'd27,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(20, ok);
      pop_cmp("to_next", ok);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_err_ovf();
      logic ok;
      gen_en = 1'b1; gen_lat = 4;
      gen_err_f = 1'b1; gen_ovf_f = 1'b1;
      set_req(3, 50, 64'd1000);
      bus.req = 4'b1000;
      wait_gnt(ok);
      bus.req = '0;
      sb.push_back('{id: 2'd3, data: 64'd1050,
                     err: 1, ovf: 1, to: 0});
      wait_rsp(20, ok);
      pop_cmp("err_ovf", ok);
      gen_err_f = 1'b0; gen_ovf_f = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic ok;
      gen_en = 1'b0;
      set_req(2, 8, 64'd2);
      set_req(1, 6, 64'd60);
      set_req(3, 9, 64'd90);
      bus.req = 4'b0100;
      wait_gnt(ok);
      n_chk++;
      if (!ok || bus.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL mid_gnt got %b want 0100", bus.gnt);
      end
      bus.req = 4'b1010;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if (gen_reset_n !== 1'b0 || bus.busy !== 1'b0 ||
          bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got %b%b%b want 000",
                  gen_reset_n, bus.busy, bus.rsp_valid);
      end
      reset = 1'b0;
      gen_en = 1'b1; gen_lat = 1;
      wait_gnt(ok);
      n_chk++;
      if (!ok || bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_lowest got %b want 0010", bus.gnt);
      end
      bus.req = 4'b1000;
      sb.push_back('{id: 2'd1, data: 64'd66,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(20, ok);
      pop_cmp("mid_first", ok);
      wait_gnt(ok);
      n_chk++;
      if (!ok || bus.gnt !== 4'b1000) begin
         n_fail++;
         $display("FAIL mid_second got %b want 1000", bus.gnt);
      end
      bus.req = '0;
      sb.push_back('{id: 2'd3, data: 64'd99,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(20, ok);
      pop_cmp("mid_second", ok);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_drop_req();
      logic ok;
      int extra;
      gen_en = 1'b1; gen_lat = 6;
      set_req(0, 4, 64'd4);
      bus.req = 4'b0001;
      wait_gnt(ok);
      bus.req = '0;
      @(negedge clk);
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      sb.push_back('{id: 2'd0, data: 64'd8,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(20, ok);
      pop_cmp("drop_job", ok);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.gnt != '0) extra++;
      end
      n_chk++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL drop_nogrant got %0d want 0", extra);
      end
   endtask

   task automatic test_precheck();
      logic ok;
      int t0;
      gen_en = 1'b1; gen_lat = 2;
      set_req(0, 94, 64'd5);
      bus.req = 4'b0001;
      wait_gnt(ok);
      t0 = cyc;
      n_chk++;
      if (!ok || bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL pre_gnt got %b want 0001", bus.gnt);
      end
      bus.req = '0;
`ifdef FIB_SCHED_PRECHECK_EN
      n_chk++;
      if (gen_load !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_noload got %b want 0", gen_load);
      end
      sb.push_back('{id: 2'd0, data: '0,
                     err: 0, ovf: 1, to: 0});
      wait_rsp(10, ok);
      n_chk++;
      if (cyc - t0 != 1) begin
         n_fail++;
         $display("FAIL pre_lat got %0d want 1", cyc - t0);
      end
      pop_cmp("precheck", ok);
      @(negedge clk);
      n_chk++;
      if (gen_clear !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_noclear got %b%b want 00",
                  gen_clear, bus.busy);
      end
`else
      n_chk++;
      if (gen_load !== 1'b1 || gen_order !== 16'd94) begin
         n_fail++;
         $display("FAIL pre_fwd got %b/%0d want 1/94",
                  gen_load, gen_order);
      end
      sb.push_back('{id: 2'd0, data: 64'd99,
                     err: 0, ovf: 0, to: 0});
      wait_rsp(20, ok);
      n_chk++;
      if (cyc - t0 != 4) begin
         n_fail++;
         $display("FAIL pre_lat got %0d want 4", cyc - t0);
      end
      pop_cmp("forward", ok);
`endif
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_err_ovf();
      test_reset_mid_run();
      test_drop_req();
      test_precheck();
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_empty got %0d want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Round-robin scheduler that shares one fsm_num_gen Fibonacci generator among NUM_REQ requesters.
- Accepts jobs (order, start value) from requesters and sequences the generator through load, run and clear.
- Returns a tagged result with status, and recovers the generator with a timeout plus local reset if it hangs.
- Sits between the requester fabric and the generator instance in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 64, generator data width
ORDER_WIDTH, 16, generator order width
TIMEOUT_CYCLES, 1024, max cycles in RUN before forced recovery
MAX_ORDER, 93, largest order representable in DATA_WIDTH (used by optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester job request; held until gnt
req_order  in  NUM_REQ*ORDER_WIDTH  packed per-requester order
req_start  in  NUM_REQ*DATA_WIDTH  packed per-requester start value
gnt  out  NUM_REQ  one-hot, one-cycle job-accept pulse
busy  out  1  high whenever state is not IDLE
rsp_valid  out  1  one-cycle result pulse
rsp_id  out  clog2(NUM_REQ)  requester index of the result
rsp_data  out  DATA_WIDTH  result value
rsp_error  out  1  generator reported error
rsp_overflow  out  1  generator or precheck reported overflow
rsp_timeout  out  1  job aborted by timeout
gen_reset_n  out  1  active-low reset to generator
gen_load  out  1  generator load strobe
gen_clear  out  1  generator clear strobe
gen_order  out  ORDER_WIDTH  order to generator
gen_data_in  out  DATA_WIDTH  start value to generator
gen_done  in  1  generator done
gen_error  in  1  generator error
gen_overflow  in  1  generator overflow
gen_data_out  in  DATA_WIDTH  generator result

Behaviour:
- Reset values:
  - State IDLE.
  - All strobes and rsp_* outputs 0; gen_reset_n 0 while reset is high, 1 afterwards.
  - RR pointer 0, timeout counter 0, job registers 0.
- States: IDLE, LOAD, RUN, RESP, CLEAR, RECOVER.
- IDLE:
  - If any req is set at an edge, choose the first requester at or after the RR pointer, wrapping.
  - Latch its index, order and start into job registers and go to LOAD.
  - Set the pointer to winner+1 mod NUM_REQ.
- LOAD (1 cycle):
  - gnt[id] high and gen_load high.
  - gen_order and gen_data_in driven from job registers; they hold these values through RUN.
  - Then go to RUN with counter cleared.
- RUN:
  - Sample gen_done and gen_error each edge.
  - If either is high, capture gen_data_out and the gen_* flags, then go to RESP.
  - Otherwise increment the counter.
  - At counter == TIMEOUT_CYCLES-1 with no done, go to RECOVER.
- Simultaneous events: done together with timeout terminal count means done wins. error together with done means rsp_error=1 and data is still passed through.
- RESP (1 cycle):
  - rsp_valid high; rsp_id, rsp_data and flags come from captured values.
  - rsp_* are held stable until the next RESP; only rsp_valid pulses.
  - Go to CLEAR.
- CLEAR (1 cycle): gen_clear high, then go to IDLE.
- RECOVER (2 cycles):
  - gen_reset_n low.
  - Then go to RESP with rsp_timeout=1, rsp_data=0, other flags 0.
  - Skip CLEAR and return to IDLE directly after RESP.
- Minimum grant-to-grant spacing is 5 cycles (LOAD, RUN×1, RESP, CLEAR, IDLE).
- A req dropped before gnt is never granted. Req bits of non-winners are ignored until the next IDLE.
- Reset mid-job aborts without any response; the pointer returns to 0.

Optional Feature:
- Macro FIB_SCHED_PRECHECK_EN.
- When defined: in IDLE, a winner with order > MAX_ORDER is still granted (gnt pulses for 1 cycle in a LOAD-equivalent slot), but gen_load stays 0. The scheduler then goes straight to RESP with rsp_overflow=1, rsp_data=0, and returns to IDLE without CLEAR.
- When undefined: every job is forwarded to the generator unchanged.

Test Plan:
- Single req[0] with order=10, start=1, generator done after 12 cycles → gnt[0] in LOAD cycle; gen_order=10; rsp_valid with rsp_id=0 and rsp_data=gen_data_out; gen_clear pulse follows.
- req=4'b1111 held continuously → grant order 0,1,2,3,0; each requester exactly once per four grants.
- Generator never asserts done → rsp_timeout=1 exactly TIMEOUT_CYCLES+3 cycles after LOAD; gen_reset_n low for 2 cycles; the next job proceeds normally.
- gen_done and gen_error high together, with gen_overflow=1 → rsp_error=1 and rsp_overflow=1, rsp_data captured.
- reset pulsed during RUN → no rsp_valid; gen_reset_n low; state IDLE; the next grant goes to the lowest pending index.
- With FIB_SCHED_PRECHECK_EN, order=94 → gnt pulse with no gen_load, then rsp_overflow=1 and rsp_data=0. With the macro undefined, the same job is forwarded to the generator.
